// File: rtl/ula_pkg.sv
// Shared widths, constants and FSM encoding for the ULA arithmetic blocks.
package ula_pkg;

    localparam int ULA_W     = 32;
    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = $clog2(DIV_ITERS);

    localparam logic [ULA_W-1:0]     DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [DIV_CNT_W-1:0] DIV_LAST  = DIV_CNT_W'(DIV_ITERS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/full_adder_32bit_sub.sv
// 32-bit ripple subtractor a - b built as a + ~b + 1.
// carry_out = 1 means no borrow, i.e. a >= b (unsigned).
module full_adder_32bit_sub
    import ula_pkg::*;
(
    input  logic [ULA_W-1:0] a,
    input  logic [ULA_W-1:0] b,
    output logic [ULA_W-1:0] s,
    output logic             carry_out,
    output logic             overflow
);

    logic [ULA_W-1:0] w_nb;

    assign w_nb = ~b;

    always_comb begin
        logic [ULA_W:0] v_c;
        v_c       = '0;
        s         = '0;
        v_c[0]    = 1'b1;
        for (int i = 0; i < ULA_W; i++) begin
            s[i]     = a[i] ^ w_nb[i] ^ v_c[i];
            v_c[i+1] = (a[i] & w_nb[i]) | (v_c[i] & (a[i] ^ w_nb[i]));
        end
        carry_out = v_c[ULA_W];
        // Signed overflow: carry into the sign bit differs from carry out of it.
        overflow  = v_c[ULA_W] ^ v_c[ULA_W-1];
    end

endmodule

// File: rtl/ula_div_seq.sv
// Sequential unsigned 32-bit restoring divider, one quotient bit per cycle.
// The trial subtraction reuses the ULA subtractor; its borrow decides each bit.
module ula_div_seq
    import ula_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ULA_W-1:0] dividend,
    input  logic [ULA_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [ULA_W-1:0] quotient,
    output logic [ULA_W-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    div_state_t           r_state;
    logic [ULA_W-1:0]     r_q;
    logic [ULA_W-1:0]     r_r;
    logic [ULA_W-1:0]     r_d;
    logic [DIV_CNT_W-1:0] r_cnt;
    logic                 r_dz;

    logic [ULA_W-1:0]     w_t;
    logic [ULA_W-1:0]     w_s;
    logic                 w_no_borrow;
    logic                 w_sub_ovf_unused;

    // Partial remainder shifted left with the next dividend bit; r[31] is always 0 here.
    assign w_t = {r_r[ULA_W-2:0], r_q[ULA_W-1]};

    full_adder_32bit_sub u_sub (
        .a         (w_t),
        .b         (r_d),
        .s         (w_s),
        .carry_out (w_no_borrow),
        .overflow  (w_sub_ovf_unused)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_r     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_d   <= divisor;
                        r_cnt <= '0;
                        if (divisor != '0) begin
                            r_state <= RUN;
                            r_q     <= dividend;
                            r_r     <= '0;
                            r_dz    <= 1'b0;
                        end else begin
                            r_state <= DONE;
                            r_q     <= DIV0_QUOT;
                            r_r     <= dividend;
                            r_dz    <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    if (w_no_borrow) begin
                        r_r <= w_s;
                        r_q <= {r_q[ULA_W-2:0], 1'b1};
                    end else begin
                        r_r <= w_t;
                        r_q <= {r_q[ULA_W-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + DIV_CNT_W'(1);
                    if (r_cnt == DIV_LAST) begin
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign quotient    = r_q;
    assign remainder   = r_r;
    assign div_by_zero = r_dz;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_ula_div_seq.sv
// Self-checking bench for ula_div_seq: directed corner cases plus randomized
// divisions scored against plain / and % arithmetic.
module tb_ula_div_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    // Expected entries are {div_by_zero, quotient, remainder}.
    logic [64:0] exp_q[$];

    ula_div_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
        return {1'b0, a / b, a % b};
    endfunction

    // Called at a sample point; start is taken at the next rising edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back(model(a, b));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits for done, checking latency, busy span and results. inject_at >= 0
    // pulses a stray 50/5 start at that sample while the divider is running.
    task automatic wait_done(input string tag, input int exp_lat, input int inject_at);
        int          n;
        int          busy_cnt;
        logic [64:0] e;
        n        = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && n < 100) begin
            if (busy === 1'b1) begin
                busy_cnt++;
                chk($sformatf("%s_r31", tag), {31'd0, remainder[31]}, 32'd0);
            end
            if (n == inject_at) begin
                start    = 1'b1;
                dividend = 32'd50;
                divisor  = 32'd5;
            end else if (inject_at >= 0 && n == inject_at + 1) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("%s_done_seen", tag), {31'd0, done}, 32'd1);
        if (done === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("%s_latency", tag), n, exp_lat);
            chk($sformatf("%s_busy_cycles", tag), busy_cnt, exp_lat);
            chk($sformatf("%s_busy_at_done", tag), {31'd0, busy}, 32'd0);
            chk($sformatf("%s_quot", tag), quotient, e[63:32]);
            chk($sformatf("%s_rem", tag), remainder, e[31:0]);
            chk($sformatf("%s_dz", tag), {31'd0, div_by_zero}, {31'd0, e[64]});
        end else begin
            exp_q.delete();
        end
    endtask

    task automatic done_drop(input string tag);
        @(posedge clk); #1;
        chk($sformatf("%s_pulse", tag), {31'd0, done}, 32'd0);
        chk($sformatf("%s_held_q", tag), {31'd0, busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk($sformatf("%s_busy", tag), {31'd0, busy}, 32'd0);
        chk($sformatf("%s_done", tag), {31'd0, done}, 32'd0);
        chk($sformatf("%s_quot", tag), quotient, 32'd0);
        chk($sformatf("%s_rem", tag), remainder, 32'd0);
        chk($sformatf("%s_dz", tag), {31'd0, div_by_zero}, 32'd0);
        chk($sformatf("%s_state", tag), {30'd0, dbg_state}, 32'd0);
    endtask

    initial begin
        int          seen_done;
        logic [31:0] a;
        logic [31:0] b;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        launch(32'd100, 32'd7);
        wait_done("d100_7", 32, -1);
        done_drop("d100_7");

        launch(32'hFFFF_FFFF, 32'h8000_0001);
        wait_done("dmax_half", 32, -1);
        done_drop("dmax_half");

        launch(32'hFFFF_FFFF, 32'd1);
        wait_done("dmax_1", 32, -1);
        done_drop("dmax_1");

        // Divide by zero goes straight to DONE after the accepting edge.
        launch(32'd5, 32'd0);
        wait_done("d5_0", 0, -1);
        done_drop("d5_0");
        launch(32'd9, 32'd3);
        wait_done("d9_3", 32, -1);
        done_drop("d9_3");

        launch(32'd100, 32'd7);
        wait_done("ignore_start", 32, 10);
        done_drop("ignore_start");

        // Back-to-back: next start presented during the DONE cycle.
        launch(32'd100, 32'd7);
        wait_done("b2b_first", 32, -1);
        launch(32'd12, 32'd5);
        wait_done("b2b_second", 32, -1);
        launch(32'd7, 32'd0);
        wait_done("b2b_div0", 0, -1);
        done_drop("b2b_div0");

        // Reset in the middle of a run abandons it.
        launch(32'd100, 32'd7);
        repeat (14) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_all_zero("mid_reset");
        rst_n = 1'b1;
        exp_q.delete();
        seen_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done = 1;
        end
        chk("mid_reset_no_done", seen_done, 0);
        launch(32'd100, 32'd7);
        wait_done("after_reset", 32, -1);
        done_drop("after_reset");

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = $urandom >> $urandom_range(0, 31);
                3:       b = a >> $urandom_range(0, 4);
                default: b = $urandom;
            endcase
            launch(a, b);
            wait_done($sformatf("rnd%0d", i), (b == 32'd0) ? 0 : 32, -1);
            if ($urandom_range(0, 1) == 0) done_drop($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
